ysyx_22050612_core_ctrl: RTL and testbench
==========================================

YSYX_22050612_CORE_CTRL -- requirements
Module: ysyx_22050612_core_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 SHALL have parameter CNT_W, 64, width of cycle and instret counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports ifu_req output 1 (fetch request), ifu_addr output 64 (fetch address, equals pc), ifu_valid input 1 (fetch data valid), ifu_inst input 32 (fetched word).
REQ-006 SHALL have port inst output 32: latched instruction driven to the IDU.
REQ-007 SHALL have inputs is_load 1, is_store 1, is_halt 1 (instruction-class flags decoded by the IDU from inst) and next_pc 64 (EXU result: branch/jump target or pc+4).
REQ-008 SHALL have ports lsu_req output 1 (memory access request) and lsu_done input 1 (access complete).
REQ-009 SHALL have outputs rf_wen 1 (register-file write enable), pc 64, retire 1 (one-cycle retirement pulse), halted 1, bad_pc 1 (misaligned-target flag), cycle_cnt CNT_W, instret_cnt CNT_W.

Function
REQ-010 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 FETCH: ifu_req=1; stay until ifu_valid=1, then latch ifu_inst into inst and go to DECODE.
REQ-012 ifu_valid outside FETCH SHALL be ignored; inst SHALL hold its value outside FETCH.
REQ-013 DECODE: one cycle; if is_halt=1 go to HALT with retire=1 for that cycle, else go to EXEC.
REQ-014 EXEC: one cycle; go to MEM if is_load or is_store, else go to WB.
REQ-015 MEM: lsu_req=1; stay until lsu_done=1, then go to WB; lsu_done outside MEM SHALL be ignored.
REQ-016 WB: one cycle; rf_wen=1 unless is_store=1; retire=1; pc<=next_pc; go to FETCH.
REQ-017 If next_pc[1:0]!=2'b00 in WB: pc unchanged, rf_wen=0, retire=0, bad_pc<=1, go to HALT.
REQ-018 HALT SHALL be absorbing until rst; all request and enable outputs 0; halted=1.
REQ-019 ifu_req, lsu_req, rf_wen, retire SHALL be decoded from current state only (Moore).
REQ-020 Minimum latency SHALL be 4 cycles per non-memory instruction with ifu_valid returned in the first FETCH cycle; 5 plus LSU wait for loads/stores.
REQ-021 cycle_cnt SHALL increment every cycle outside HALT; instret_cnt SHALL increment on every retire pulse, including the halt retirement.
REQ-022 Counters SHALL wrap modulo 2^CNT_W without a flag.

Reset
REQ-023 On rst=1 at a clock edge: state<=FETCH, pc<=PC_RESET, inst<=32'h0, bad_pc<=0, both counters<=0, from any state including MEM and HALT.
REQ-024 During the reset cycle ifu_req, lsu_req, rf_wen, retire SHALL be 0; halted=0.
REQ-025 An outstanding fetch or LSU access interrupted by reset SHALL be abandoned; a late ifu_valid/lsu_done is handled per REQ-012/015.

Structure
REQ-026 A shared package SHALL hold the state enumeration, PC_RESET and the halt encoding 32'h00100073.
REQ-027 One sub-module, ysyx_22050612_perf_cnt (enable-gated, synchronous-clear CNT_W counter), SHALL be instantiated twice.

Verification
REQ-028 addi (is_* all 0), ifu_valid on first FETCH cycle, next_pc=PC_RESET+4 -> retire at cycle 4, rf_wen=1 same cycle, pc=64'h80000004 afterwards, instret_cnt=1.
REQ-029 lw with lsu_done delayed 3 cycles -> lsu_req high exactly 4 cycles, retire at cycle 8, rf_wen=1.
REQ-030 sw -> WB with rf_wen=0, retire=1, instret_cnt incremented.
REQ-031 inst 32'h00100073 with is_halt=1 -> retire pulse in DECODE, then halted=1, cycle_cnt frozen, ifu_valid pulses ignored.
REQ-032 next_pc=64'h80000006 -> bad_pc=1, halted=1, pc stays 64'h80000000, retire=0.
REQ-033 rst asserted mid-MEM -> next cycle FETCH, pc=PC_RESET, counters 0; lsu_done arriving afterwards has no effect.

Source files
------------

// File: rtl/ysyx_22050612_core_ctrl_pkg.sv
// Shared definitions for the multi-cycle core controller: state codes,
// reset PC, halt encoding and a PC alignment helper.
package ysyx_22050612_core_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;

  localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] S_WB     = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT   = 3'd5;

  localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] HALT_INST        = 32'h0010_0073;

  function automatic logic pc_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050612_core_ctrl_perf_cnt.sv
// Enable-gated free-running counter with synchronous clear; wraps silently.
module ysyx_22050612_perf_cnt #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_22050612_core_ctrl.sv
// Multi-cycle core sequencer: FETCH/DECODE/EXEC/MEM/WB with halt on ebreak
// or misaligned target, plus cycle and retired-instruction counters.
module ysyx_22050612_core_ctrl
  import ysyx_22050612_core_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  output logic [63:0]      ifu_addr,
  input  logic             ifu_valid,
  input  logic [31:0]      ifu_inst,
  output logic [31:0]      inst,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic [63:0]      next_pc,
  output logic             lsu_req,
  input  logic             lsu_done,
  output logic             rf_wen,
  output logic [63:0]      pc,
  output logic             retire,
  output logic             halted,
  output logic             bad_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic               bad_pc_q, bad_pc_d;
  logic               wb_ok;

  assign wb_ok = pc_aligned(next_pc);

  // Next-state: fetch/LSU handshakes only matter in their own state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    bad_pc_d = bad_pc_q;
    case (state_q)
      S_FETCH: begin
        if (ifu_valid) begin
          inst_d  = ifu_inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (lsu_done) state_d = S_WB;
      end
      S_WB: begin
        if (wb_ok) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end else begin
          bad_pc_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      inst_q   <= 32'h0;
      bad_pc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      bad_pc_q <= bad_pc_d;
    end
  end

  // Strobes come from the state; rst masks them so the reset cycle is quiet.
  assign ifu_req  = !rst && (state_q == S_FETCH);
  assign lsu_req  = !rst && (state_q == S_MEM);
  assign rf_wen   = !rst && (state_q == S_WB) && !is_store && wb_ok;
  assign retire   = !rst && (((state_q == S_DECODE) && is_halt) ||
                              ((state_q == S_WB) && wb_ok));
  assign halted   = !rst && (state_q == S_HALT);
  assign ifu_addr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign bad_pc   = bad_pc_q;

  ysyx_22050612_perf_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .clr (rst),
    .en  (state_q != S_HALT),
    .cnt (cycle_cnt)
  );

  ysyx_22050612_perf_cnt #(.W(CNT_W)) u_instret_cnt (
    .clk (clk),
    .clr (rst),
    .en  (retire),
    .cnt (instret_cnt)
  );

endmodule

// File: tb/tb_ysyx_22050612_core_ctrl.sv
// Self-checking bench for the core controller: instruction table with
// scoreboard, halt hold-off and reset-during-MEM sequences.
module tb_ysyx_22050612_core_ctrl;
  import ysyx_22050612_core_ctrl_pkg::*;

  localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_valid = 1'b0;
  logic [31:0] ifu_inst = 32'h0;
  logic [31:0] inst;
  logic        is_load = 1'b0, is_store = 1'b0, is_halt = 1'b0;
  logic [63:0] next_pc = 64'h0;
  logic        lsu_req;
  logic        lsu_done = 1'b0;
  logic        rf_wen;
  logic [63:0] pc;
  logic        retire, halted, bad_pc;
  logic [63:0] cycle_cnt, instret_cnt;

  ysyx_22050612_core_ctrl #(.PC_RESET(PCR), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_valid(ifu_valid), .ifu_inst(ifu_inst),
    .inst(inst), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
    .next_pc(next_pc), .lsu_req(lsu_req), .lsu_done(lsu_done), .rf_wen(rf_wen),
    .pc(pc), .retire(retire), .halted(halted), .bad_pc(bad_pc),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;     // 0 alu/jump, 1 load, 2 store, 3 halt
    logic [63:0] npc;
    int          ifu_dly;
    int          lsu_dly;
    logic        noise;
    logic [31:0] word;
    int          e_ret;    // cycle index of retire pulse, 0 = none
    int          e_wen;    // number of rf_wen cycles
    int          e_lsu;    // number of lsu_req cycles
    logic [63:0] e_pc;
    logic        e_bad;
    int          e_cyc;    // cycles counted by cycle_cnt
  } vec_t;

  typedef struct {
    int          ret_cyc;
    int          wen_cnt;
    int          lsu_cyc;
    logic [63:0] pc;
    logic [63:0] instret;
    logic [63:0] cyc;
    logic        halted;
    logic        bad;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[9];
  int          total = 0;
  int          bad = 0;
  logic [63:0] pc_m, instret_m, cyc_m;
  logic [31:0] inst_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ifu_req", 64'(ifu_req), 64'd0);
    chk("rst_lsu_req", 64'(lsu_req), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, PCR);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_bad_pc", 64'(bad_pc), 64'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_fetch", 64'(ifu_req), 64'd1);
    pc_m = PCR; instret_m = 64'd0; cyc_m = 64'd0; inst_m = 32'h0;
  endtask

  // Drives one instruction from its first FETCH cycle to the next FETCH or HALT.
  task automatic run_inst(input vec_t v, input string tag);
    exp_t e, got;
    int   k, fseen, mseen, ret_k, wen_n, lsu_n;
    logic left, done;
    e.ret_cyc = v.e_ret;  e.wen_cnt = v.e_wen;  e.lsu_cyc = v.e_lsu;
    e.pc      = v.e_pc;   e.bad     = v.e_bad;  e.halted  = (v.kind == 3) || v.e_bad;
    e.instret = instret_m + ((v.e_ret != 0) ? 64'd1 : 64'd0);
    e.cyc     = cyc_m + 64'(v.e_cyc);
    e.inst    = v.word;
    sb.push_back(e);
    is_load = (v.kind == 1); is_store = (v.kind == 2); is_halt = (v.kind == 3);
    next_pc = v.npc;
    fseen = 0; mseen = 0; ret_k = 0; wen_n = 0; lsu_n = 0; left = 1'b0; done = 1'b0;
    for (k = 1; k <= 60; k++) begin
      if (k > 1) begin
        @(negedge clk);
        if (halted || (ifu_req && left)) begin
          done = 1'b1;
          break;
        end
      end
      ifu_valid = 1'b0; lsu_done = 1'b0; ifu_inst = ~v.word;
      if (ifu_req) begin
        if (fseen == v.ifu_dly) begin
          ifu_valid = 1'b1;
          ifu_inst  = v.word;
        end
        fseen++;
      end else if (v.noise) ifu_valid = 1'b1;
      if (lsu_req) begin
        if (mseen == v.lsu_dly) lsu_done = 1'b1;
        mseen++;
      end else if (v.noise) lsu_done = 1'b1;
      #1;
      if (k == 1) chk({tag, "_ifu_addr"}, ifu_addr, pc_m);
      if (!ifu_req) left = 1'b1;
      if (retire && ret_k == 0) ret_k = k;
      if (rf_wen) wen_n++;
      if (lsu_req) lsu_n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: no FETCH/HALT after 60 cycles", tag);
    end
    got = sb.pop_front();
    chk({tag, "_retire_cyc"}, 64'(ret_k), 64'(got.ret_cyc));
    chk({tag, "_rf_wen_cnt"}, 64'(wen_n), 64'(got.wen_cnt));
    chk({tag, "_lsu_req_cnt"}, 64'(lsu_n), 64'(got.lsu_cyc));
    chk({tag, "_pc"}, pc, got.pc);
    chk({tag, "_instret"}, instret_cnt, got.instret);
    chk({tag, "_cycle"}, cycle_cnt, got.cyc);
    chk({tag, "_halted"}, 64'(halted), 64'(got.halted));
    chk({tag, "_bad_pc"}, 64'(bad_pc), 64'(got.bad));
    chk({tag, "_inst"}, 64'(inst), 64'(got.inst));
    pc_m = got.pc; instret_m = got.instret; cyc_m = got.cyc; inst_m = got.inst;
  endtask

  // HALT must ignore fetch and LSU handshakes and freeze the cycle counter.
  task automatic hold_check();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ifu_valid = 1'b1; ifu_inst = $urandom; lsu_done = 1'b1;
      #1;
      if (ifu_req || lsu_req || rf_wen || retire) begin
        total++; bad++;
        $display("FAIL halt_strobe: req/wen/retire active in HALT (%b%b%b%b)",
                 ifu_req, lsu_req, rf_wen, retire);
      end
    end
    chk("halt_hold_halted", 64'(halted), 64'd1);
    chk("halt_hold_cycle", cycle_cnt, cyc_m);
    chk("halt_hold_instret", instret_cnt, instret_m);
    chk("halt_hold_inst", 64'(inst), 64'(inst_m));
    chk("halt_hold_pc", pc, pc_m);
    ifu_valid = 1'b0; lsu_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 64'h8000_0004, 0, 0, 1'b0, 32'h0050_0093, 4, 1, 0, 64'h8000_0004, 1'b0, 4};
    tbl[1] = '{1, 64'h8000_0008, 0, 3, 1'b0, 32'h0000_a103, 8, 1, 4, 64'h8000_0008, 1'b0, 8};
    tbl[2] = '{2, 64'h8000_000c, 0, 0, 1'b0, 32'h0020_a023, 5, 0, 1, 64'h8000_000c, 1'b0, 5};
    tbl[3] = '{0, 64'h8000_0010, 2, 0, 1'b1, 32'h0010_0113, 6, 1, 0, 64'h8000_0010, 1'b0, 6};
    tbl[4] = '{0, 64'h8000_0110, 0, 0, 1'b0, 32'h1000_00ef, 4, 1, 0, 64'h8000_0110, 1'b0, 4};
    tbl[5] = '{0, 64'h8000_0108, 0, 0, 1'b0, 32'hfe00_0ce3, 4, 1, 0, 64'h8000_0108, 1'b0, 4};
    tbl[6] = '{1, 64'h8000_010c, 1, 1, 1'b1, 32'h0041_2183, 7, 1, 2, 64'h8000_010c, 1'b0, 7};
    tbl[7] = '{3, 64'h8000_0110, 0, 0, 1'b0, HALT_INST,    2, 0, 0, 64'h8000_010c, 1'b0, 2};
    tbl[8] = '{0, 64'h8000_0006, 0, 0, 1'b0, 32'h0000_0013, 0, 0, 0, 64'h8000_0000, 1'b1, 4};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_inst(tbl[i], $sformatf("v%0d", i));
      if (tbl[i].kind == 3 || tbl[i].e_bad) begin
        hold_check();
        do_reset();
      end
    end

    // Reset while a load waits in MEM; the late lsu_done must be ignored.
    is_load = 1'b1; is_store = 1'b0; is_halt = 1'b0; next_pc = 64'h8000_0004;
    ifu_valid = 1'b1; ifu_inst = 32'h0000_a103;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      ifu_valid = 1'b0; lsu_done = 1'b0;
    end
    #1;
    chk("mid_mem_lsu_req", 64'(lsu_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_mem_rst_lsu_req", 64'(lsu_req), 64'd0);
    @(negedge clk);
    rst = 1'b0; lsu_done = 1'b1;
    #1;
    chk("mid_mem_fetch", 64'(ifu_req), 64'd1);
    chk("mid_mem_pc", pc, PCR);
    chk("mid_mem_cycle", cycle_cnt, 64'd0);
    chk("mid_mem_instret", instret_cnt, 64'd0);
    @(negedge clk);
    lsu_done = 1'b0;
    #1;
    chk("late_done_fetch", 64'(ifu_req), 64'd1);
    chk("late_done_lsu_req", 64'(lsu_req), 64'd0);
    chk("late_done_cycle", cycle_cnt, 64'd1);
    pc_m = PCR; instret_m = 64'd0; cyc_m = 64'd1; inst_m = 32'h0;
    run_inst(tbl[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
